// File: rtl/pulse_seq_gen.sv
// pulse_seq_gen: multi-channel one-shot pulse sequencer with holdoff,
// per-channel retrigger mode, busy status and sticky missed-trigger flags.
module pulse_seq_gen #(
  parameter int CHANNELS  = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP       = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] x_in,
  input  logic [CHANNELS-1:0] mode_retrig,
  input  logic                miss_clr,
  output logic [CHANNELS-1:0] y_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] miss
);
  localparam int MAXLEN = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
  localparam int CW = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LD = (GAP > 0) ? CW'(GAP - 1) : '0;
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PULSE, S_GAP} state_e;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          x_prev_q;
    logic          miss_q;
    logic          rise;
    logic          miss_d;
    assign rise = ~x_prev_q & x_in[c];
    // an edge is lost in holdoff, or mid-pulse when the channel cannot retrigger
    assign miss_d = (miss_q & ~miss_clr) |
                    (rise & ((state_q == S_GAP) | ((state_q == S_PULSE) & ~mode_retrig[c])));
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        x_prev_q <= 1'b1;
        miss_q   <= 1'b0;
      end else begin
        x_prev_q <= x_in[c];
        miss_q   <= miss_d;
        case (state_q)
          S_IDLE:  if (!x_in[c]) state_q <= S_ARMED;
          S_ARMED: if (x_in[c]) begin
            state_q <= S_PULSE;
            cnt_q   <= PULSE_LD;
          end
          S_PULSE: if (mode_retrig[c] && rise) cnt_q <= PULSE_LD;
          else if (cnt_q == '0) begin
            state_q <= (GAP > 0) ? S_GAP : S_IDLE;
            cnt_q   <= GAP_LD;
          end else cnt_q <= cnt_q - 1'b1;
          S_GAP:   if (cnt_q == '0) state_q <= S_IDLE;
          else cnt_q <= cnt_q - 1'b1;
          default: state_q <= S_IDLE;
        endcase
      end
    end
    assign y_out[c] = state_q == S_PULSE;
    assign busy[c]  = (state_q == S_PULSE) || (state_q == S_GAP);
    assign miss[c]  = miss_q;
  end
endmodule

// File: tb/tb_pulse_seq_gen.sv
// tb_pulse_seq_gen: directed and randomized checks of pulse_seq_gen against a
// remaining-cycles behavioural model, for default and PULSE_LEN=1/GAP=0 builds.
module tb_pulse_seq_gen;
  localparam int CH = 4, PL = 3, GP = 2, CH1 = 2;
  logic clock = 0, reset = 1;
  logic [CH-1:0] x_in = '0, mode_retrig = '0;
  logic miss_clr = 0;
  logic [CH-1:0] y_out, busy, miss;
  logic [CH1-1:0] x1 = '0, m1 = '0;
  logic clr1 = 0;
  logic [CH1-1:0] y1, b1, ms1;
  int compared = 0, mismatched = 0;
  bit started = 0;
  always #5 clock = ~clock;
  pulse_seq_gen dut (.clock(clock), .reset(reset), .x_in(x_in), .mode_retrig(mode_retrig),
    .miss_clr(miss_clr), .y_out(y_out), .busy(busy), .miss(miss));
  pulse_seq_gen #(.CHANNELS(CH1), .PULSE_LEN(1), .GAP(0)) dut1 (.clock(clock), .reset(reset),
    .x_in(x1), .mode_retrig(m1), .miss_clr(clr1), .y_out(y1), .busy(b1), .miss(ms1));
  typedef struct {int rp; int rg; bit armed; bit prev; bit miss;} ch_t;
  ch_t ma[CH];
  ch_t mb[CH1];
  // rp/rg count the pulse/holdoff cycles still to be shown, including the current one
  function automatic ch_t step(ch_t s, bit x, bit m, bit clr, bit rst, int pl, int gp);
    ch_t n = s;
    bit e = !s.prev && x;
    bit set = 0;
    if (rst) begin
      n = '{0, 0, 0, 1, 0};
      return n;
    end
    if (s.rp > 0) begin
      if (e && m) n.rp = pl;
      else begin
        set = e;
        n.rp = s.rp - 1;
        if (n.rp == 0) n.rg = gp;
      end
    end else if (s.rg > 0) begin
      set = e;
      n.rg = s.rg - 1;
    end else if (!s.armed) n.armed = !x;
    else if (x) begin
      n.rp = pl;
      n.armed = 0;
    end
    n.miss = (s.miss && !clr) || set;
    n.prev = x;
    return n;
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(posedge clock) begin
    if (reset) started <= 1;
    for (int i = 0; i < CH; i++) ma[i] = step(ma[i], x_in[i], mode_retrig[i], miss_clr, reset, PL, GP);
    for (int i = 0; i < CH1; i++) mb[i] = step(mb[i], x1[i], m1[i], clr1, reset, 1, 0);
  end
  always @(negedge clock) if (started) begin
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("model y[%0d]", i), 32'(y_out[i]), 32'(ma[i].rp > 0));
      chk($sformatf("model busy[%0d]", i), 32'(busy[i]), 32'(ma[i].rp > 0 || ma[i].rg > 0));
      chk($sformatf("model miss[%0d]", i), 32'(miss[i]), 32'(ma[i].miss));
    end
    for (int i = 0; i < CH1; i++) begin
      chk($sformatf("model1 y[%0d]", i), 32'(y1[i]), 32'(mb[i].rp > 0));
      chk($sformatf("model1 busy[%0d]", i), 32'(b1[i]), 32'(mb[i].rp > 0 || mb[i].rg > 0));
      chk($sformatf("model1 miss[%0d]", i), 32'(ms1[i]), 32'(mb[i].miss));
    end
  end
  logic [9:0] ry[CH], rb[CH], rm[CH];
  logic [8:0] rp1;
  initial begin
    repeat (2) @(negedge clock);
    chk("reset y", 32'(y_out), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset miss", 32'(miss), 0);
    reset = 0;
    @(negedge clock);
    x_in = 4'hF;
    mode_retrig = 4'b0100;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clock);
      for (int i = 0; i < CH; i++) begin
        ry[i][j-1] = y_out[i];
        rb[i][j-1] = busy[i];
        rm[i][j-1] = miss[i];
      end
      if (j == 1) x_in[2] = 0;
      if (j == 2) begin x_in[1] = 0; x_in[2] = 1; end
      if (j == 3) begin x_in[1] = 1; x_in[2] = 0; x_in[3] = 0; end
      if (j == 4) begin x_in[2] = 1; x_in[3] = 1; end
    end
    chk("ch0 y wave", 32'(ry[0]), 32'h007);
    chk("ch0 busy wave", 32'(rb[0]), 32'h01F);
    chk("ch0 miss wave", 32'(rm[0]), 32'h000);
    chk("ch1 y wave", 32'(ry[1]), 32'h007);
    chk("ch1 miss wave", 32'(rm[1]), 32'h3F8);
    chk("ch2 retrig y wave", 32'(ry[2]), 32'h07F);
    chk("ch2 retrig busy wave", 32'(rb[2]), 32'h1FF);
    chk("ch2 miss wave", 32'(rm[2]), 32'h000);
    chk("ch3 y wave", 32'(ry[3]), 32'h007);
    chk("ch3 busy wave", 32'(rb[3]), 32'h01F);
    chk("ch3 gap miss wave", 32'(rm[3]), 32'h3F0);
    miss_clr = 1;
    @(negedge clock);
    miss_clr = 0;
    chk("miss after clr", 32'(miss), 0);
    x_in[1] = 0;
    @(negedge clock);
    x_in[1] = 1;
    @(negedge clock);
    chk("ch1 refire y", 32'(y_out[1]), 1);
    x_in[1] = 0;
    @(negedge clock);
    x_in[1] = 1;
    miss_clr = 1;
    @(negedge clock);
    miss_clr = 0;
    chk("set beats clr", 32'(miss), 32'h2);
    repeat (6) @(negedge clock);
    x_in = 0;
    @(negedge clock);
    x_in = 4'hF;
    @(negedge clock);
    chk("all fire y", 32'(y_out), 32'hF);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("mid-pulse reset y", 32'(y_out), 0);
    chk("mid-pulse reset busy", 32'(busy), 0);
    chk("mid-pulse reset miss", 32'(miss), 0);
    repeat (3) begin
      @(negedge clock);
      chk("held high no fire", 32'(y_out), 0);
    end
    x_in = 0;
    @(negedge clock);
    x_in = 4'hF;
    @(negedge clock);
    chk("fire after low-high", 32'(y_out), 32'hF);
    for (int k = 0; k < 20; k++) begin
      x1[0] = ~x1[0];
      @(negedge clock);
    end
    x1 = 2'b11;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 9; k++) begin
      x1[0] = (k % 3 == 1);
      @(negedge clock);
      rp1[k] = y1[0];
    end
    chk("len1 period-3 pulses", 32'(rp1), 32'h092);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++) if ($urandom_range(2) == 0) x_in[i] = ~x_in[i];
      for (int i = 0; i < CH1; i++) if ($urandom_range(2) == 0) x1[i] = ~x1[i];
      if ($urandom_range(15) == 0) mode_retrig = CH'($urandom);
      if ($urandom_range(15) == 0) m1 = CH1'($urandom);
      miss_clr = ($urandom_range(15) == 0);
      clr1 = ($urandom_range(15) == 0);
      reset = ($urandom_range(299) == 0);
      @(negedge clock);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
